// File: rtl/gray_seq_ctrl.sv
// Binary/Gray position sequencer: free-run, single-step handshake, load, up/down count.
// Every output is a register; Gray is recomputed from the next binary value.
module gray_seq_ctrl #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         dir,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         step_req,
  output logic         step_ack,
  output logic [N-1:0] bin_out,
  output logic [N-1:0] gray_out,
  output logic         gray_valid,
  output logic         wrap,
  output logic         running
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e       state_q;
  logic [N-1:0] bin_q, gray_q;
  logic         step_ack_q, gray_valid_q, wrap_q, running_q;

  logic [N-1:0] bin_d;
  logic         wrap_d;
  logic         step_ok;

  always_comb begin
    bin_d  = dir ? bin_q - 1'b1 : bin_q + 1'b1;
    wrap_d = dir ? (bin_q == '0) : (bin_q == '1);
  end

  // A held request is accepted only every other cycle because ack blocks re-acceptance.
  assign step_ok = (state_q == IDLE) && step_req && !step_ack_q && !start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bin_q        <= '0;
      gray_q       <= '0;
      step_ack_q   <= 1'b0;
      gray_valid_q <= 1'b0;
      wrap_q       <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      step_ack_q   <= 1'b0;
      gray_valid_q <= 1'b0;
      wrap_q       <= 1'b0;

      if (stop)
        state_q <= IDLE;
      else if (state_q == IDLE && start)
        state_q <= RUN;
      running_q <= !stop && ((state_q == RUN) || start);

      if (load) begin
        bin_q        <= load_val;
        gray_q       <= load_val ^ (load_val >> 1);
        gray_valid_q <= 1'b1;
      end else if (stop) begin
        // stop freezes the count for this cycle
      end else if (state_q == RUN) begin
        bin_q        <= bin_d;
        gray_q       <= bin_d ^ (bin_d >> 1);
        gray_valid_q <= 1'b1;
        wrap_q       <= wrap_d;
      end else if (step_ok) begin
        bin_q        <= bin_d;
        gray_q       <= bin_d ^ (bin_d >> 1);
        gray_valid_q <= 1'b1;
        wrap_q       <= wrap_d;
        step_ack_q   <= 1'b1;
      end
    end
  end

  assign step_ack   = step_ack_q;
  assign bin_out    = bin_q;
  assign gray_out   = gray_q;
  assign gray_valid = gray_valid_q;
  assign wrap       = wrap_q;
  assign running    = running_q;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Directed vector bench for gray_seq_ctrl (N=4): table of cycle vectors plus async-reset sequence.
module tb_gray_seq_ctrl;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, stop, dir, load, step_req;
  logic [N-1:0] load_val;
  logic         step_ack, gray_valid, wrap, running;
  logic [N-1:0] bin_out, gray_out;

  int checks   = 0;
  int failures = 0;

  gray_seq_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir), .load(load),
    .load_val(load_val), .step_req(step_req), .step_ack(step_ack), .bin_out(bin_out),
    .gray_out(gray_out), .gray_valid(gray_valid), .wrap(wrap), .running(running)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start, stop, dir, load, step_req;
    logic [3:0] lv;
    logic [3:0] e_bin, e_gray;
    logic       e_gv, e_wrap, e_ack, e_run;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic st, sp, d, ld, sr, input logic [3:0] lv,
                     input logic [3:0] b, g, input logic gv, wr, ak, rn);
    vec_t v;
    v.start = st; v.stop = sp; v.dir = d; v.load = ld; v.step_req = sr; v.lv = lv;
    v.e_bin = b; v.e_gray = g; v.e_gv = gv; v.e_wrap = wr; v.e_ack = ak; v.e_run = rn;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic st, sp, d, ld, sr, input logic [3:0] lv);
    start = st; stop = sp; dir = d; load = ld; step_req = sr; load_val = lv;
  endtask

  task automatic check_outs(input int idx, input logic [3:0] b, g, input logic gv, wr, ak, rn);
    chk("bin_out", idx, 32'(bin_out), 32'(b));
    chk("gray_out", idx, 32'(gray_out), 32'(g));
    chk("gray_valid", idx, 32'(gray_valid), 32'(gv));
    chk("wrap", idx, 32'(wrap), 32'(wr));
    chk("step_ack", idx, 32'(step_ack), 32'(ak));
    chk("running", idx, 32'(running), 32'(rn));
  endtask

  logic [3:0] up_gray [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                               4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

  initial begin
    logic [3:0] prev_gray;

    //  st sp d ld sr lv   | bin  gray gv wr ak rn
    add(1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++)
      add(0, 0, 0, 0, 0, 4'h0, 4'(i + 1), up_gray[i], 1, (i == 15), 0, 1);
    add(0, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 4'h5, 4'h5, 4'h7, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 4'h0, 4'h6, 4'h5, 1, 0, 1, 0);
    add(0, 0, 0, 0, 1, 4'h0, 4'h6, 4'h5, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 4'h0, 4'h7, 4'h4, 1, 0, 1, 0);
    add(0, 0, 0, 0, 1, 4'h0, 4'h7, 4'h4, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 4'h0, 4'h7, 4'h4, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 4'h0, 4'h7, 4'h4, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 4'h1, 4'h1, 4'h1, 1, 0, 0, 0);
    add(1, 0, 1, 0, 0, 4'h0, 4'h1, 4'h1, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 1, 0, 0, 1);
    add(0, 0, 1, 0, 0, 4'h0, 4'hF, 4'h8, 1, 1, 0, 1);
    add(0, 1, 1, 0, 0, 4'h0, 4'hF, 4'h8, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 4'h0, 4'hF, 4'h8, 0, 0, 0, 0);
    add(1, 0, 0, 1, 1, 4'hA, 4'hA, 4'hF, 1, 0, 0, 1);
    add(0, 0, 0, 0, 1, 4'h0, 4'hB, 4'hE, 1, 0, 0, 1);
    add(0, 1, 0, 0, 0, 4'h0, 4'hB, 4'hE, 0, 0, 0, 0);

    drive(0, 0, 0, 0, 0, 4'h0);
    rst = 1'b1;
    #12;
    check_outs(-1, 4'h0, 4'h0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    prev_gray = gray_out;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].start, vecs[i].stop, vecs[i].dir, vecs[i].load, vecs[i].step_req, vecs[i].lv);
      @(posedge clk);
      #1;
      check_outs(i, vecs[i].e_bin, vecs[i].e_gray, vecs[i].e_gv, vecs[i].e_wrap,
                 vecs[i].e_ack, vecs[i].e_run);
      if (gray_valid && !vecs[i].load)
        chk("gray_1bit", i, 32'($countones(gray_out ^ prev_gray)), 32'd1);
      prev_gray = gray_out;
    end

    // Async reset mid-run at bin=9, asserted between edges.
    drive(0, 0, 0, 1, 0, 4'h8);
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0, 4'h0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 4'h0);
    @(posedge clk); #1;
    check_outs(100, 4'h9, 4'hD, 1, 0, 0, 1);
    #2 rst = 1'b1;
    #1;
    check_outs(101, 4'h0, 4'h0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_outs(102 + k, 4'h0, 4'h0, 0, 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
